// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT pipeline types and helpers
package fft_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/mdc_delay_commutator_if.sv
// rtl/mdc_delay_commutator_if.sv - dual-path complex sample stream bundle
interface mdc_delay_commutator_if #(
    parameter int DATA_W = fft_pkg::DATA_W
) ();

    logic              io_in_valid;
    logic [DATA_W-1:0] io_in0_re;
    logic [DATA_W-1:0] io_in0_im;
    logic [DATA_W-1:0] io_in1_re;
    logic [DATA_W-1:0] io_in1_im;
    logic              io_out_valid;
    logic [DATA_W-1:0] io_out0_re;
    logic [DATA_W-1:0] io_out0_im;
    logic [DATA_W-1:0] io_out1_re;
    logic [DATA_W-1:0] io_out1_im;

    modport master (
        output io_in_valid, io_in0_re, io_in0_im, io_in1_re, io_in1_im,
        input  io_out_valid, io_out0_re, io_out0_im, io_out1_re, io_out1_im
    );

    modport slave (
        input  io_in_valid, io_in0_re, io_in0_im, io_in1_re, io_in1_im,
        output io_out_valid, io_out0_re, io_out0_im, io_out1_re, io_out1_im
    );

endinterface

// File: rtl/mdc_delay_line.sv
// rtl/mdc_delay_line.sv - DEPTH-beat circular-buffer delay, read-before-write
module mdc_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // A one-entry line still needs a one-bit pointer; it just never leaves 0.
    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // The slot about to be overwritten holds the sample from DEPTH beats ago.
    assign dout = mem[ptr];

    // Storage is deliberately left unreset; stale contents are masked by priming.
    always_ff @(posedge clock) begin
        if (en) mem[ptr] <= din;
    end

    // Pointer advances once per accepted beat, wrapping at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mdc_delay_commutator.sv
// rtl/mdc_delay_commutator.sv - radix-2 MDC delay/commutator between FFT stages
module mdc_delay_commutator
    import fft_pkg::clog2;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input logic                         clock,
    input logic                         reset,
    mdc_delay_commutator_if.slave       io
);

    localparam int CNT_W   = clog2(2 * DEPTH);
    localparam int SEL_BIT = clog2(DEPTH);
    localparam int FILL_W  = clog2(DEPTH + 1);
    localparam int W2      = 2 * DATA_W;

    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill;
    logic              beat;
    logic              sel;
    logic              primed;
    logic [W2-1:0]     a_word;
    logic [W2-1:0]     b_word;
    logic [W2-1:0]     d_word;
    logic [W2-1:0]     l_in;
    logic [W2-1:0]     l_out;
    logic [W2-1:0]     out0_next;

    assign beat   = io.io_in_valid;
    assign sel    = cnt[SEL_BIT];
    assign primed = (fill == FILL_W'(DEPTH));
    assign a_word = {io.io_in0_re, io.io_in0_im};
    assign b_word = {io.io_in1_re, io.io_in1_im};

    mdc_delay_line #(.DEPTH(DEPTH), .WIDTH(W2)) u_line (
        .clock (clock),
        .reset (reset),
        .en    (beat),
        .din   (a_word),
        .dout  (d_word)
    );

    mdc_delay_line #(.DEPTH(DEPTH), .WIDTH(W2)) l_line (
        .clock (clock),
        .reset (reset),
        .en    (beat),
        .din   (l_in),
        .dout  (l_out)
    );

    // Crossbar: straight routes delayed upper to out0, cross swaps it with the lower path.
    always_comb begin
        out0_next = d_word;
        l_in      = b_word;
        if (sel) begin
            out0_next = b_word;
            l_in      = d_word;
        end
    end

    // Beat counter wraps naturally at 2*DEPTH; fill saturates once both lines hold real data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            fill <= '0;
        end else if (beat) begin
            cnt <= cnt + 1'b1;
            if (!primed) fill <= fill + 1'b1;
        end
    end

    // Output registers load on every beat and hold across stalls; valid marks primed beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io.io_out_valid <= 1'b0;
            io.io_out0_re   <= '0;
            io.io_out0_im   <= '0;
            io.io_out1_re   <= '0;
            io.io_out1_im   <= '0;
        end else begin
            io.io_out_valid <= beat && primed;
            if (beat) begin
                {io.io_out0_re, io.io_out0_im} <= out0_next;
                {io.io_out1_re, io.io_out1_im} <= l_out;
            end
        end
    end

endmodule
